// File: rtl/src_pkg.sv
// Shared types and defaults for the branch/PC unit: the resolution FSM states
// and the reset-time parameters.
package src_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      EVAL    = 3'd1,
      WAIT    = 3'd2,
      RESOLVE = 3'd3,
      DONE    = 3'd4
   } state_e;

   localparam int          C_W_DEF      = 19;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage : src_pkg

// File: rtl/branch_pc_unit_if.sv
// Request/status bundle between the sequencer and the branch/PC unit.
interface branch_pc_unit_if;

   logic        start;
   logic [31:0] ir;
   logic        pc_inc;
   logic        pc_load;
   logic [31:0] pc_load_val;
   logic        con_out;
   logic        con_in;
   logic [31:0] pc;
   logic        busy;
   logic        done;
   logic        taken;

   modport master (
      output start, ir, pc_inc, pc_load, pc_load_val, con_out,
      input  con_in, pc, busy, done, taken
   );

   modport slave (
      input  start, ir, pc_inc, pc_load, pc_load_val, con_out,
      output con_in, pc, busy, done, taken
   );

endinterface : branch_pc_unit_if

// File: rtl/pc_reg.sv
// 32-bit program counter register with asynchronous active-low clear and a
// load enable.
module pc_reg
   import src_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        clear_n,
   input  logic        load_en,
   input  logic [31:0] d,
   output logic [31:0] q
);

   // PC storage: clear to RESET_PC, otherwise load when enabled.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         q <= RESET_PC;
      end else if (load_en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule : pc_reg

// File: rtl/branch_pc_unit.sv
// Program counter with increment/absolute load and a multi-cycle conditional
// branch resolver that strobes the external CON flip-flop.
module branch_pc_unit
   import src_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          C_W      = C_W_DEF
) (
   input  logic             clk,
   input  logic             clear_n,
   branch_pc_unit_if.slave  bus
);

   state_e      state_r;
   logic        con_in_r;
   logic        busy_r;
   logic        done_r;
   logic        taken_r;
   logic [31:0] pc_s;
   logic [31:0] pc_d_s;
   logic        pc_we_s;
   logic [31:0] disp_s;
   logic        unused_ir_s;

   // Upper IR bits carry the condition code consumed by the external CON logic.
   assign unused_ir_s = ^bus.ir[31:C_W];
   assign disp_s      = {{(32 - C_W){bus.ir[C_W-1]}}, bus.ir[C_W-1:0]};

   // Next-PC select; only IDLE requests and a taken branch in RESOLVE write.
   always_comb begin
      pc_we_s = 1'b0;
      pc_d_s  = pc_s;
      case (state_r)
         IDLE: begin
            if (bus.pc_load) begin
               pc_we_s = 1'b1;
               pc_d_s  = bus.pc_load_val;
            end else if (bus.start) begin
               pc_we_s = 1'b0;
               pc_d_s  = pc_s;
            end else if (bus.pc_inc) begin
               pc_we_s = 1'b1;
               pc_d_s  = pc_s + 32'd1;
            end else begin
               pc_we_s = 1'b0;
               pc_d_s  = pc_s;
            end
         end
         RESOLVE: begin
            if (bus.con_out) begin
               pc_we_s = 1'b1;
               pc_d_s  = pc_s + disp_s;
            end else begin
               pc_we_s = 1'b0;
               pc_d_s  = pc_s;
            end
         end
         default: begin
            pc_we_s = 1'b0;
            pc_d_s  = pc_s;
         end
      endcase
   end

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (clk),
      .clear_n (clear_n),
      .load_en (pc_we_s),
      .d       (pc_d_s),
      .q       (pc_s)
   );

   // Resolution FSM; status outputs are set alongside the state they describe.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_r  <= IDLE;
         con_in_r <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         taken_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (!bus.pc_load && bus.start) begin
                  state_r  <= EVAL;
                  con_in_r <= 1'b1;
                  busy_r   <= 1'b1;
               end else begin
                  state_r  <= IDLE;
               end
            end
            EVAL: begin
               state_r  <= WAIT;
               con_in_r <= 1'b0;
            end
            WAIT: begin
               state_r <= RESOLVE;
            end
            RESOLVE: begin
               state_r <= DONE;
               taken_r <= bus.con_out;
               done_r  <= 1'b1;
            end
            DONE: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r  <= IDLE;
               con_in_r <= 1'b0;
               busy_r   <= 1'b0;
               done_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc     = pc_s;
   assign bus.con_in = con_in_r;
   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.taken  = taken_r;

endmodule : branch_pc_unit

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: vector table of branches, a done-driven
// scoreboard, and hand sequences for latency, priority, busy masking and reset.
module tb_branch_pc_unit;
   import src_pkg::*;

   logic clk = 1'b0;
   logic clear_n = 1'b0;
   always #5 clk = ~clk;

   branch_pc_unit_if bus ();

   branch_pc_unit #(
      .RESET_PC (32'h0000_0000),
      .C_W      (19)
   ) dut (
      .clk     (clk),
      .clear_n (clear_n),
      .bus     (bus.slave)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] pc0;
      logic [18:0] disp;
      logic        co;
      logic [31:0] exp_pc;
      logic        exp_taken;
   } vec_t;

   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[8];
   int   errors = 0;
   int   checks = 0;
   int   done_count = 0;
   int   done_snap;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest pending branch.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         done_count++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending branch");
         end else begin
            mon_e = sb_q.pop_front();
            check("done_pc", bus.pc, mon_e.pc);
            check("done_taken", {31'd0, bus.taken}, {31'd0, mon_e.taken});
         end
      end
   end

   task automatic load_pc(input logic [31:0] v);
      bus.pc_load     = 1'b1;
      bus.pc_load_val = v;
      @(negedge clk);
      bus.pc_load     = 1'b0;
      check("load_pc", bus.pc, v);
   endtask

   task automatic drive_start(input logic [18:0] disp, input logic co,
                              input logic [31:0] exp_pc, input logic exp_taken);
      logic [31:0] r;
      r          = $urandom();
      r[18:0]    = disp;
      bus.ir     = r;
      bus.con_out = co;
      bus.start  = 1'b1;
      sb_q.push_back(exp_t'{pc: exp_pc, taken: exp_taken});
   endtask

   task automatic run_branch(input vec_t v);
      load_pc(v.pc0);
      drive_start(v.disp, v.co, v.exp_pc, v.exp_taken);
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 10 && bus.busy === 1'b1; i++) @(negedge clk);
      check({v.name, "_idle"}, {31'd0, bus.busy}, 32'd0);
      check({v.name, "_pc"}, bus.pc, v.exp_pc);
      check({v.name, "_taken"}, {31'd0, bus.taken}, {31'd0, v.exp_taken});
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{"fwd5",     32'h0000_0010, 19'h00005, 1'b1, 32'h0000_0015, 1'b1};
      vecs[1] = '{"back2",    32'h0000_0010, 19'h7FFFE, 1'b1, 32'h0000_000E, 1'b1};
      vecs[2] = '{"nottaken", 32'h0000_0010, 19'h7FFFE, 1'b0, 32'h0000_0010, 1'b0};
      vecs[3] = '{"wrapneg",  32'h0000_0000, 19'h7FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
      vecs[4] = '{"wrappos",  32'hFFFF_FFF0, 19'h00020, 1'b1, 32'h0000_0010, 1'b1};
      vecs[5] = '{"maxpos",   32'h0000_1000, 19'h3FFFF, 1'b1, 32'h0004_0FFF, 1'b1};
      vecs[6] = '{"maxneg",   32'h0010_0000, 19'h40000, 1'b1, 32'h000C_0000, 1'b1};
      vecs[7] = '{"zero",     32'h0000_1234, 19'h00000, 1'b1, 32'h0000_1234, 1'b1};

      bus.start = 1'b0; bus.ir = 32'd0; bus.pc_inc = 1'b0; bus.pc_load = 1'b0;
      bus.pc_load_val = 32'd0; bus.con_out = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_pc", bus.pc, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_con_in", {31'd0, bus.con_in}, 32'd0);
      check("rst_taken", {31'd0, bus.taken}, 32'd0);
      clear_n = 1'b1;

      // Increment after release
      @(negedge clk);
      check("inc_pc0", bus.pc, 32'd0);
      bus.pc_inc = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("inc_pc", bus.pc, 32'(i));
         check("inc_busy", {31'd0, bus.busy}, 32'd0);
      end
      bus.pc_inc = 1'b0;

      // Cycle-accurate latency of a taken branch
      load_pc(32'h0000_0010);
      drive_start(19'h00005, 1'b1, 32'h0000_0015, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
      check("lat_con_in_n1", {31'd0, bus.con_in}, 32'd1);
      check("lat_busy_n1", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      check("lat_con_in_n2", {31'd0, bus.con_in}, 32'd0);
      check("lat_done_n2", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      check("lat_pc_n3", bus.pc, 32'h0000_0010);
      @(negedge clk);
      check("lat_pc_n4", bus.pc, 32'h0000_0015);
      check("lat_done_n4", {31'd0, bus.done}, 32'd1);
      @(negedge clk);
      check("lat_done_n5", {31'd0, bus.done}, 32'd0);
      check("lat_busy_n5", {31'd0, bus.busy}, 32'd0);

      for (int i = 0; i < 8; i++) run_branch(vecs[i]);

      // Wrap on increment, then pc_load beats start and pc_inc
      load_pc(32'hFFFF_FFFF);
      bus.pc_inc = 1'b1;
      @(negedge clk);
      bus.pc_inc = 1'b0;
      check("inc_wrap", bus.pc, 32'd0);
      bus.pc_load = 1'b1; bus.pc_load_val = 32'h40; bus.start = 1'b1; bus.pc_inc = 1'b1;
      @(negedge clk);
      bus.pc_load = 1'b0; bus.start = 1'b0; bus.pc_inc = 1'b0;
      check("prio_pc", bus.pc, 32'h40);
      check("prio_busy", {31'd0, bus.busy}, 32'd0);

      // Requests while busy (including start during DONE) are ignored
      load_pc(32'h0000_0010);
      done_snap = done_count;
      drive_start(19'h00003, 1'b1, 32'h0000_0013, 1'b1);
      @(negedge clk);
      bus.pc_inc = 1'b1; bus.pc_load = 1'b1; bus.pc_load_val = 32'h999;
      repeat (4) @(negedge clk);
      bus.start = 1'b0; bus.pc_inc = 1'b0; bus.pc_load = 1'b0;
      check("busy_mask_pc", bus.pc, 32'h0000_0013);
      check("busy_mask_idle", {31'd0, bus.busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("busy_mask_one_done", 32'(done_count - done_snap), 32'd1);
      check("busy_mask_pc_hold", bus.pc, 32'h0000_0013);

      // Reset during WAIT aborts the branch
      load_pc(32'h0000_0077);
      drive_start(19'h00009, 1'b1, 32'h0000_0080, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check("abort_in_wait", {31'd0, bus.busy}, 32'd1);
      clear_n = 1'b0;
      sb_q.delete();
      done_snap = done_count;
      #1;
      check("abort_pc", bus.pc, 32'd0);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_con_in", {31'd0, bus.con_in}, 32'd0);
      repeat (2) @(negedge clk);
      clear_n = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_no_done", 32'(done_count - done_snap), 32'd0);
      check("abort_pc_hold", bus.pc, 32'd0);
      bus.pc_inc = 1'b1;
      @(negedge clk);
      bus.pc_inc = 1'b0;
      check("abort_then_inc", bus.pc, 32'd1);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_branch_pc_unit
